// File: rtl/matmul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// matmul_pkg: shared state, pipeline-tag types and limits for matmul_ctrl_gen.
// Rev 1.0
// ---------------------------------------------------------------------------
package matmul_pkg;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;
  // The drain counter runs 0..READ_LAT, so it must hold READ_LAT_MAX.
  localparam int DRAIN_W = $clog2(READ_LAT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } matmul_state_e;

  typedef struct packed {
    logic valid;
    logic first;
  } en_tag_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_en_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// matmul_en_pipe: READ_LAT-deep {valid, first} delay line driving the MAC enables.
// Rev 1.0
// ---------------------------------------------------------------------------
module matmul_en_pipe
  import matmul_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  en_tag_t issue_tag,
  output logic    en_PPReg,
  output logic    en_FDReg,
  output logic    en_Mux
);

  en_tag_t r_stage [READ_LAT];
  en_tag_t r_fd;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < READ_LAT; s++) r_stage[s] <= '0;
      r_fd <= '0;
    end else begin
      r_stage[0] <= issue_tag;
      for (int s = 1; s < READ_LAT; s++) r_stage[s] <= r_stage[s-1];
      r_fd <= r_stage[READ_LAT-1];
    end
  end

  assign en_PPReg = r_stage[READ_LAT-1].valid;
  assign en_FDReg = r_fd.valid;
  // First term of a dot product bypasses the accumulator.
  assign en_Mux   = r_fd.valid & ~r_fd.first;

endmodule
`default_nettype wire

// File: rtl/matmul_ctrl_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// matmul_ctrl_gen: start/busy/done controller for C = A*B read/MAC/write sequencing.
// MATMUL_CTRL_PERF_EN adds the saturating cycle_count port.  Rev 1.0
// ---------------------------------------------------------------------------
module matmul_ctrl_gen
  import matmul_pkg::*;
#(
  parameter  int ROWS     = 10,
  parameter  int INNER    = 10,
  parameter  int COLS     = 10,
  parameter  int READ_LAT = 1,
  localparam int RW       = $clog2(max2(ROWS, 2)),
  localparam int KW       = $clog2(max2(INNER, 2)),
  localparam int CW       = $clog2(max2(COLS, 2))
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
`ifdef MATMUL_CTRL_PERF_EN
  output logic [31:0]   cycle_count,
`endif
  output logic          en_ReadMat_A,
  output logic [RW-1:0] rowAddr_A,
  output logic [KW-1:0] colAddr_A,
  output logic          en_ReadMat_B,
  output logic [KW-1:0] rowAddr_B,
  output logic [CW-1:0] colAddr_B,
  output logic          en_PPReg,
  output logic          en_Mux,
  output logic          en_FDReg,
  output logic          en_WriteMat_C,
  output logic [RW-1:0] rowAddr_C,
  output logic [CW-1:0] colAddr_C
);

  localparam logic [RW-1:0]      I_LAST     = RW'(ROWS - 1);
  localparam logic [KW-1:0]      K_LAST     = KW'(INNER - 1);
  localparam logic [CW-1:0]      J_LAST     = CW'(COLS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LAT);

  matmul_state_e        r_state;
  logic [RW-1:0]        r_i;
  logic [KW-1:0]        r_k;
  logic [CW-1:0]        r_j;
  logic [DRAIN_W-1:0]   r_drain;
  logic                 w_issue;
  logic                 w_write;
  en_tag_t              w_tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= ISSUE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
          end
        end
        ISSUE: begin
          if (r_k == K_LAST) begin
            r_k     <= '0;
            r_drain <= '0;
            r_state <= DRAIN;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_drain <= '0;
            r_state <= WRITE;
          end else begin
            r_drain <= r_drain + DRAIN_W'(1);
          end
        end
        WRITE: begin
          if (r_i == I_LAST && r_j == J_LAST) begin
            r_i     <= '0;
            r_j     <= '0;
            r_state <= DONE;
          end else begin
            if (r_j == J_LAST) begin
              r_j <= '0;
              r_i <= r_i + RW'(1);
            end else begin
              r_j <= r_j + CW'(1);
            end
            r_state <= ISSUE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_issue = (r_state == ISSUE);
  assign w_write = (r_state == WRITE);

  assign busy          = w_issue | (r_state == DRAIN) | w_write;
  assign done          = (r_state == DONE);
  assign en_ReadMat_A  = w_issue;
  assign en_ReadMat_B  = w_issue;
  assign rowAddr_A     = w_issue ? r_i : '0;
  assign colAddr_A     = w_issue ? r_k : '0;
  assign rowAddr_B     = w_issue ? r_k : '0;
  assign colAddr_B     = w_issue ? r_j : '0;
  assign en_WriteMat_C = w_write;
  assign rowAddr_C     = w_write ? r_i : '0;
  assign colAddr_C     = w_write ? r_j : '0;

  assign w_tag = '{valid: w_issue, first: (r_k == '0)};

  matmul_en_pipe #(.READ_LAT(READ_LAT)) u_en_pipe (
    .clk       (clk),
    .reset     (reset),
    .issue_tag (w_tag),
    .en_PPReg  (en_PPReg),
    .en_FDReg  (en_FDReg),
    .en_Mux    (en_Mux)
  );

`ifdef MATMUL_CTRL_PERF_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (r_state == IDLE && start) begin
      r_cycle_count <= '0;
    end else if (busy && r_cycle_count != '1) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_ctrl_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_matmul_ctrl_gen: directed + random checks of two matmul_ctrl_gen configs
// against a cycle-index reference model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_matmul_ctrl_gen;

  typedef struct packed {
    logic       busy, done, rd_a;
    logic [7:0] row_a, col_a;
    logic       rd_b;
    logic [7:0] row_b, col_b;
    logic       pp, mux, fd, wr;
    logic [7:0] row_c, col_c;
  } obs_t;

  localparam int TOT_A = 2 * 2 * (3 + 1 + 2);
  localparam int TOT_B = 1 * 1 * (1 + 3 + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, start_a, busy_a, done_a, rda_a, rdb_a, pp_a, mux_a, fd_a, wr_a;
  logic [0:0] rowA_a, rowC_a, colB_a, colC_a;
  logic [1:0] colA_a, rowB_a;
  logic reset_b, start_b, busy_b, done_b, rda_b, rdb_b, pp_b, mux_b, fd_b, wr_b;
  logic [0:0] rowA_b, colA_b, rowB_b, colB_b, rowC_b, colC_b;
`ifdef MATMUL_CTRL_PERF_EN
  logic [31:0] cc_a, cc_b;
  longint      cnt_a, cnt_b;
`endif

  matmul_ctrl_gen #(.ROWS(2), .INNER(3), .COLS(2), .READ_LAT(1)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .busy(busy_a), .done(done_a),
`ifdef MATMUL_CTRL_PERF_EN
    .cycle_count(cc_a),
`endif
    .en_ReadMat_A(rda_a), .rowAddr_A(rowA_a), .colAddr_A(colA_a),
    .en_ReadMat_B(rdb_a), .rowAddr_B(rowB_a), .colAddr_B(colB_a),
    .en_PPReg(pp_a), .en_Mux(mux_a), .en_FDReg(fd_a),
    .en_WriteMat_C(wr_a), .rowAddr_C(rowC_a), .colAddr_C(colC_a)
  );

  matmul_ctrl_gen #(.ROWS(1), .INNER(1), .COLS(1), .READ_LAT(3)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .busy(busy_b), .done(done_b),
`ifdef MATMUL_CTRL_PERF_EN
    .cycle_count(cc_b),
`endif
    .en_ReadMat_A(rda_b), .rowAddr_A(rowA_b), .colAddr_A(colA_b),
    .en_ReadMat_B(rdb_b), .rowAddr_B(rowB_b), .colAddr_B(colB_b),
    .en_PPReg(pp_b), .en_Mux(mux_b), .en_FDReg(fd_b),
    .en_WriteMat_C(wr_b), .rowAddr_C(rowC_b), .colAddr_C(colC_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {busy_a, done_a, rda_a, 8'(rowA_a), 8'(colA_a), rdb_a, 8'(rowB_a),
                  8'(colB_a), pp_a, mux_a, fd_a, wr_a, 8'(rowC_a), 8'(colC_a)};
  assign obs_b = {busy_b, done_b, rda_b, 8'(rowA_b), 8'(colA_b), rdb_b, 8'(rowB_b),
                  8'(colB_b), pp_b, mux_b, fd_b, wr_b, 8'(rowC_b), 8'(colC_b)};

  int n_vec = 0;
  int n_err = 0;
  int p_a = 0;
  int p_b = 0;

  // p = cycle index within a run: 0 idle, 1..tot busy, tot+1 the done cycle.
  function automatic obs_t model(input int R, input int K, input int C, input int L, input int p);
    obs_t o;
    int per, tot, off, e;
    o   = '0;
    per = K + L + 2;
    tot = R * C * per;
    if (p == tot + 1) begin
      o.done = 1'b1;
    end else if (p >= 1 && p <= tot) begin
      off    = (p - 1) % per;
      e      = (p - 1) / per;
      o.busy = 1'b1;
      if (off < K) begin
        o.rd_a = 1'b1; o.row_a = 8'(e / C); o.col_a = 8'(off);
        o.rd_b = 1'b1; o.row_b = 8'(off);   o.col_b = 8'(e % C);
      end
      o.pp  = (off >= L && off <= K - 1 + L);
      o.fd  = (off >= L + 1 && off <= K + L);
      o.mux = o.fd && (off != L + 1);
      if (off == K + L + 1) begin
        o.wr = 1'b1; o.row_c = 8'(e / C); o.col_c = 8'(e % C);
      end
    end
    return o;
  endfunction

  function automatic int nxt(input int p, input int tot, input logic st, input logic rs);
    if (rs)         return 0;
    if (p == 0)     return st ? 1 : 0;
    if (p <= tot)   return p + 1;
    return 0;
  endfunction

  task automatic chk_vec(input string tag, input obs_t obs, input obs_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
`ifdef MATMUL_CTRL_PERF_EN
    if (reset_a || (p_a == 0 && start_a)) cnt_a = 0;
    else if (p_a >= 1 && p_a <= TOT_A && cnt_a < 64'hFFFF_FFFF) cnt_a++;
    if (reset_b || (p_b == 0 && start_b)) cnt_b = 0;
    else if (p_b >= 1 && p_b <= TOT_B && cnt_b < 64'hFFFF_FFFF) cnt_b++;
`endif
    p_a = nxt(p_a, TOT_A, start_a, reset_a);
    p_b = nxt(p_b, TOT_B, start_b, reset_b);
    #1;
    chk_vec("outputs_A", obs_a, model(2, 3, 2, 1, p_a));
    chk_vec("outputs_B", obs_b, model(1, 1, 1, 3, p_b));
`ifdef MATMUL_CTRL_PERF_EN
    chk_int("cycle_count_A", longint'(cc_a), cnt_a);
    chk_int("cycle_count_B", longint'(cc_b), cnt_b);
`endif
  endtask

  initial begin
    int busy_n, wr_n, done_at, done_n;
    int wr_cyc [4];
    reset_a = 1'b1; start_a = 1'b0;
    reset_b = 1'b1; start_b = 1'b0;
`ifdef MATMUL_CTRL_PERF_EN
    cnt_a = 0; cnt_b = 0;
`endif
    step(); step();
    reset_a = 1'b0; reset_b = 1'b0;
    step();

    // 2x3x2, READ_LAT=1 single run
    busy_n = 0; wr_n = 0; done_at = 0;
    for (int w = 0; w < 4; w++) wr_cyc[w] = 0;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      if (n > 1) step();
      if (busy_a) busy_n++;
      if (wr_a) begin
        if (wr_n < 4) wr_cyc[wr_n] = n;
        wr_n++;
      end
      if (done_a) done_at = n;
    end
    chk_int("busy_cycles_A", busy_n, 24);
    chk_int("write_count_A", wr_n, 4);
    chk_int("done_cycle_A", done_at, 25);
    for (int w = 0; w < 4; w++) chk_int("write_cycle_A", wr_cyc[w], 6 * (w + 1));
`ifdef MATMUL_CTRL_PERF_EN
    step(); step();
    chk_int("cycle_count_hold_A", longint'(cc_a), 24);
`endif

    // 1x1x1, READ_LAT=3 single run
    busy_n = 0; wr_n = 0; done_at = 0;
    start_b = 1'b1; step(); start_b = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) step();
      if (busy_b) busy_n++;
      if (wr_b) wr_n = n;
      if (done_b) done_at = n;
    end
    chk_int("busy_cycles_B", busy_n, 6);
    chk_int("write_cycle_B", wr_n, 6);
    chk_int("done_cycle_B", done_at, 7);

    // reset during the drain of element (0,1), then restart
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int n = 2; n <= 10; n++) step();
    reset_a = 1'b1; step(); reset_a = 1'b0;
    wr_n = 0;
    for (int n = 0; n < 4; n++) begin
      if (wr_a) wr_n++;
      step();
    end
    chk_int("no_write_after_reset", wr_n, 0);
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int n = 2; n <= 6; n++) step();
    chk_int("restart_write_en", wr_a, 1);
    chk_int("restart_write_addr", {rowC_a, colC_a}, 0);
    for (int n = 0; n < 22; n++) step();

    // start held high across runs
    done_n = 0;
    start_a = 1'b1;
    for (int n = 1; n <= 56; n++) begin
      step();
      if (done_a) done_n++;
    end
    start_a = 1'b0;
    chk_int("held_start_done_count", done_n, 2);
    for (int n = 0; n < 30; n++) step();

    // random starts and resets on both instances
    for (int n = 0; n < 1200; n++) begin
      start_a = ($urandom_range(0, 7) == 0);
      start_b = ($urandom_range(0, 5) == 0);
      reset_a = ($urandom_range(0, 90) == 0);
      reset_b = ($urandom_range(0, 70) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matmul_ctrl_gen.md
# matmul_ctrl_gen

Parametrised control path for the matrix multiplier. It computes C = A·B with A of size ROWS×INNER and B of size INNER×COLS. It generates read addresses for the A and B memories and the load/accumulate enables for the multiply-accumulate datapath, then writes each finished C element. Compared with the fixed-size controller it adds configurable dimensions, a configurable memory read latency, and a start/busy/done handshake.

## Interface
Parameters:
- ROWS, default 10: rows of A and C; legal range 1..256.
- INNER, default 10: columns of A and rows of B (the reduction length); legal range 1..256.
- COLS, default 10: columns of B and C; legal range 1..256.
- READ_LAT, default 1: cycles from a read enable to valid read data; legal range 1..4.
- Derived localparams:
  - RW = $clog2(max(ROWS,2)).
  - KW = $clog2(max(INNER,2)).
  - CW = $clog2(max(COLS,2)).

Ports:
- clk, input, 1: the single clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a full multiply. Sampled only in IDLE.
- busy, output, 1: high from the first ISSUE cycle through the last WRITE cycle.
- done, output, 1: one-cycle pulse after the final C write.
- en_ReadMat_A, output, 1: A read enable.
- rowAddr_A, output, RW: A row address (i).
- colAddr_A, output, KW: A column address (k).
- en_ReadMat_B, output, 1: B read enable.
- rowAddr_B, output, KW: B row address (k).
- colAddr_B, output, CW: B column address (j).
- en_PPReg, output, 1: load the partial-product register from the multiplier.
- en_Mux, output, 1: accumulator input select. 0 = product only (first term of a dot product); 1 = product plus accumulator.
- en_FDReg, output, 1: load the accumulator.
- en_WriteMat_C, output, 1: C write enable.
- rowAddr_C, output, RW: C row address (i).
- colAddr_C, output, CW: C column address (j).
- cycle_count, output, 32: busy-cycle counter. Present only under MATMUL_CTRL_PERF_EN.

## Operation
- Loop counters i, j, k. Loop order: i outer, j middle, k inner.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 → ISSUE, with i=j=k=0.
  - start=0 → stay in IDLE.
- ISSUE:
  - en_ReadMat_A = en_ReadMat_B = 1.
  - Addresses: A(i,k) and B(k,j).
  - k increments every cycle.
  - When k == INNER-1: k ← 0, go to DRAIN.
- DRAIN:
  - Lasts exactly READ_LAT+1 cycles; a drain counter times it.
  - No reads are issued.
  - Then go to WRITE.
- WRITE:
  - en_WriteMat_C = 1 at address (i,j).
  - Then advance j. When j wraps (COLS-1 → 0), advance i.
  - If i == ROWS-1 and j == COLS-1: go to DONE.
  - Otherwise: go to ISSUE.
- DONE:
  - done = 1 for one cycle, then go to IDLE.
- Datapath enable pipeline:
  - A READ_LAT-deep shift register carries {valid, first} for each read. first = (k == 0).
  - en_PPReg = valid at the shift-register tail, i.e. READ_LAT cycles after the read.
  - en_FDReg = en_PPReg delayed by 1 cycle.
  - en_Mux = !first, aligned with en_FDReg.
- Address outputs when not actively used:
  - A and B addresses are 0 outside ISSUE.
  - C address is 0 outside WRITE.
- start is ignored in every state other than IDLE. A second start during busy has no effect.
- Reset, including mid-operation:
  - Next state is IDLE.
  - All counters and shift registers are cleared.
  - Every output is 0, including busy, done and cycle_count.
  - No partial write is issued after reset.
- INNER=1: ISSUE lasts 1 cycle, and en_Mux is never asserted.

## Timing
- Cycle numbering: start is sampled at edge 0, and cycle 1 is the first ISSUE cycle.
- Per C element: INNER + READ_LAT + 2 cycles, relative to the element's first ISSUE cycle t0.
  - Reads at t0 .. t0+INNER-1.
  - en_PPReg at t0+READ_LAT .. t0+INNER-1+READ_LAT.
  - en_FDReg at t0+READ_LAT+1 .. t0+INNER+READ_LAT.
  - en_WriteMat_C at t0+INNER+READ_LAT+1.
- busy is high for exactly ROWS·COLS·(INNER+READ_LAT+2) cycles.
- done is asserted on the cycle after the last WRITE.
- The earliest next accepted start is sampled during the DONE cycle's successor, i.e. in IDLE.
- All outputs are registered or decoded from registered state only. There are no combinational paths from start.

## Configuration
- MATMUL_CTRL_PERF_EN:
  - Defined: cycle_count increments on every busy cycle and saturates at 2^32-1. It is cleared on reset and on an accepted start, and holds its value after done.
  - Not defined: the cycle_count port and its counter are absent, and all other behaviour is identical.

## Structure
- Package matmul_pkg holds:
  - the state enum typedef matmul_state_e (IDLE, ISSUE, DRAIN, WRITE, DONE);
  - the shift-register entry struct typedef {valid, first};
  - the READ_LAT legal-range constants.
- One sub-module, matmul_en_pipe: a parametrised READ_LAT-deep delay line that produces en_PPReg, en_FDReg and en_Mux from the ISSUE-stage {valid, first}.

## Test plan
- ROWS=2, INNER=3, COLS=2, READ_LAT=1, start pulse:
  - busy high for 24 cycles.
  - 4 C writes, at addresses (0,0), (0,1), (1,0), (1,1), on busy cycles 6, 12, 18, 24.
  - done on cycle 25.
- Same configuration, first element:
  - A reads (0,0), (0,1), (0,2) in cycles 1–3; B reads (0,0), (1,0), (2,0) in the same cycles.
  - en_PPReg in cycles 2–4.
  - en_FDReg in cycles 3–5, with en_Mux = 0, 1, 1.
- READ_LAT=3, INNER=1, ROWS=COLS=1:
  - Read in cycle 1, en_PPReg in cycle 4, en_FDReg in cycle 5 with en_Mux=0, write in cycle 6.
  - busy for 6 cycles.
- Reset asserted in the DRAIN of element (0,1):
  - Next cycle: all outputs 0 and state IDLE, with no write to (0,1).
  - A new start restarts from (0,0).
- start held high for the whole run:
  - Only one multiply executes.
  - A new run begins in the cycle after the IDLE sample following done.
- With MATMUL_CTRL_PERF_EN, 2×3×2 at READ_LAT=1:
  - cycle_count = 24 after done, and holds.
  - It clears to 0 on the next accepted start.
